// File: rtl/ff_bank.sv
// ============================================================================
// Module   : ff_bank
// Brief    : Bank of WIDTH independent flip-flops, each run-time selectable as
//            D, T, JK or SR, with per-channel enable and registered SR-conflict
//            flag. Optional saturating transition counters are built when the
//            macro FF_BANK_TOGGLE_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       en,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic [WIDTH-1:0]       sr_err,
  input  logic                   cnt_clr,
  output logic [WIDTH*CNT_W-1:0] tgl_cnt
);

  localparam logic [1:0] C_MODE_D  = 2'b00;
  localparam logic [1:0] C_MODE_T  = 2'b01;
  localparam logic [1:0] C_MODE_JK = 2'b10;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_err;

  always_comb begin
    w_next = q;
    w_err  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        case (mode[2*i +: 2])
          C_MODE_D:  w_next[i] = a[i];
          C_MODE_T:  w_next[i] = q[i] ^ a[i];
          C_MODE_JK: begin
            case ({a[i], b[i]})
              2'b01:   w_next[i] = 1'b0;
              2'b10:   w_next[i] = 1'b1;
              2'b11:   w_next[i] = ~q[i];
              default: w_next[i] = q[i];
            endcase
          end
          default: begin
            // SR: S=R=1 keeps state and raises the conflict flag
            case ({a[i], b[i]})
              2'b01:   w_next[i] = 1'b0;
              2'b10:   w_next[i] = 1'b1;
              2'b11:   w_err[i]  = 1'b1;
              default: w_next[i] = q[i];
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= RESET_VAL;
      sr_err <= '0;
    end else begin
      q      <= w_next;
      sr_err <= w_err;
    end
  end

  assign q_bar = ~q;

`ifdef FF_BANK_TOGGLE_CNT_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over a same-edge transition; counter saturates
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (cnt_clr) begin
        r_cnt <= '0;
      end else if ((w_next[i] != q[i]) && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign tgl_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign tgl_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ff_bank.sv
// ============================================================================
// Module   : tb_ff_bank
// Brief    : Self-checking bench for ff_bank against a behavioural model;
//            honours FF_BANK_TOGGLE_CNT_EN for the counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_bank;

  localparam int               WIDTH     = 4;
  localparam int               CNT_W     = 2;
  localparam logic [WIDTH-1:0] RESET_VAL = 4'b1010;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [WIDTH-1:0]       en = '0;
  logic [2*WIDTH-1:0]     mode = '0;
  logic [WIDTH-1:0]       a = '0;
  logic [WIDTH-1:0]       b = '0;
  logic                   cnt_clr = 1'b0;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       q_bar;
  logic [WIDTH-1:0]       sr_err;
  logic [WIDTH*CNT_W-1:0] tgl_cnt;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_err;
  int               m_cnt [WIDTH];

  ff_bank #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .q(q), .q_bar(q_bar), .sr_err(sr_err), .cnt_clr(cnt_clr), .tgl_cnt(tgl_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH*CNT_W-1:0] exp_cnt();
    logic [WIDTH*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
    return v;
  endfunction

  task automatic model_reset();
    m_q   = RESET_VAL;
    m_err = '0;
    for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
  endtask

  // One rising edge of the behavioural model, using characteristic equations
  task automatic model_edge();
    logic [WIDTH-1:0] nq;
    int               sat;
    sat = (1 << CNT_W) - 1;
    nq  = m_q;
    m_err = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        case (mode[2*i +: 2])
          2'd0: nq[i] = a[i];
          2'd1: nq[i] = a[i] ? ~m_q[i] : m_q[i];
          2'd2: nq[i] = (a[i] & ~m_q[i]) | (~b[i] & m_q[i]);
          default: begin
            if (a[i] && b[i]) m_err[i] = 1'b1;
            else nq[i] = a[i] | (~b[i] & m_q[i]);
          end
        endcase
      end
`ifdef FF_BANK_TOGGLE_CNT_EN
      if (cnt_clr) m_cnt[i] = 0;
      else if (nq[i] != m_q[i] && m_cnt[i] < sat) m_cnt[i] = m_cnt[i] + 1;
`endif
    end
    m_q = nq;
  endtask

  task automatic drive(input logic [WIDTH-1:0] e, input logic [2*WIDTH-1:0] m,
                       input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic c);
    en = e; mode = m; a = aa; b = bb; cnt_clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    #2;
    total++; if (q !== RESET_VAL) begin bad++; $display("FAIL reset_init q=%b exp=%b", q, RESET_VAL); end
    drive(4'b1111, 8'h00, 4'b0101, 4'b0000, 1'b0);
    total++; if (q !== 4'b0101) begin bad++; $display("FAIL d_load q=%b exp=%b", q, 4'b0101); end
    #3 rst = 1'b1;
    #1;
    model_reset();
    total++; if (q !== 4'b1010) begin bad++; $display("FAIL reset_async_q q=%b exp=1010", q); end
    total++; if (q_bar !== 4'b0101) begin bad++; $display("FAIL reset_async_qbar q_bar=%b exp=0101", q_bar); end
    total++; if (sr_err !== 4'b0000) begin bad++; $display("FAIL reset_sr_err got=%b exp=0000", sr_err); end
    total++; if (tgl_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", tgl_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_t_mode();
    logic [WIDTH-1:0] exp_q [3];
    exp_q[0] = 4'b1111; exp_q[1] = 4'b0000; exp_q[2] = 4'b1111;
    drive(4'b1111, 8'h00, 4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b1);
    total++; if (tgl_cnt !== '0) begin bad++; $display("FAIL cnt_clr got=%h exp=0", tgl_cnt); end
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 8'h55, 4'b1111, 4'b0000, 1'b0);
      total++; if (q !== exp_q[k]) begin bad++; $display("FAIL t_mode_q step=%0d q=%b exp=%b", k, q, exp_q[k]); end
      total++; if (q_bar !== ~exp_q[k]) begin bad++; $display("FAIL t_mode_qbar step=%0d got=%b exp=%b", k, q_bar, ~exp_q[k]); end
    end
    total++; if (tgl_cnt !== exp_cnt()) begin bad++; $display("FAIL t_mode_cnt got=%h exp=%h", tgl_cnt, exp_cnt()); end
  endtask

  task automatic test_jk();
    logic [1:0] jk [5];
    logic       eq [5];
    jk[0] = 2'b10; jk[1] = 2'b01; jk[2] = 2'b11; jk[3] = 2'b11; jk[4] = 2'b00;
    eq[0] = 1'b1;  eq[1] = 1'b0;  eq[2] = 1'b1;  eq[3] = 1'b0;  eq[4] = 1'b0;
    drive(4'b0001, 8'h00, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 8'h02, {3'b000, jk[k][1]}, {3'b000, jk[k][0]}, 1'b0);
      total++; if (q[0] !== eq[k]) begin bad++; $display("FAIL jk_q0 step=%0d q0=%b exp=%b", k, q[0], eq[k]); end
      total++; if (q !== m_q) begin bad++; $display("FAIL jk_q step=%0d q=%b exp=%b", k, q, m_q); end
    end
    drive(4'b0000, 8'h02, 4'b0001, 4'b0001, 1'b0);
    total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL jk_hold q0=%b exp=0", q[0]); end
  endtask

  task automatic test_sr();
    logic q1_before;
    q1_before = m_q[1];
    drive(4'b0010, 8'hFF, 4'b0010, 4'b0010, 1'b0);
    total++; if (q[1] !== q1_before) begin bad++; $display("FAIL sr_conflict_hold q1=%b exp=%b", q[1], q1_before); end
    total++; if (sr_err !== 4'b0010) begin bad++; $display("FAIL sr_err_set got=%b exp=0010", sr_err); end
    drive(4'b0010, 8'hFF, 4'b0010, 4'b0000, 1'b0);
    total++; if (q[1] !== 1'b1) begin bad++; $display("FAIL sr_set q1=%b exp=1", q[1]); end
    total++; if (sr_err !== 4'b0000) begin bad++; $display("FAIL sr_err_clear got=%b exp=0000", sr_err); end
    drive(4'b0010, 8'hFF, 4'b0010, 4'b0010, 1'b0);
    drive(4'b0000, 8'hFF, 4'b0010, 4'b0010, 1'b0);
    total++; if (sr_err !== 4'b0000) begin bad++; $display("FAIL sr_err_disabled got=%b exp=0000", sr_err); end
  endtask

  task automatic test_saturation();
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) drive(4'b0100, 8'h10, 4'b0100, 4'b0000, 1'b0);
    total++; if (tgl_cnt !== exp_cnt()) begin bad++; $display("FAIL cnt_sat got=%h exp=%h", tgl_cnt, exp_cnt()); end
`ifdef FF_BANK_TOGGLE_CNT_EN
    total++; if (tgl_cnt[2*CNT_W +: CNT_W] !== 2'd3) begin bad++; $display("FAIL cnt_sat_ch2 got=%0d exp=3", tgl_cnt[2*CNT_W +: CNT_W]); end
`endif
    drive(4'b0100, 8'h10, 4'b0100, 4'b0000, 1'b1);
    total++; if (q !== m_q) begin bad++; $display("FAIL clr_toggle_q q=%b exp=%b", q, m_q); end
    total++; if (tgl_cnt !== '0) begin bad++; $display("FAIL clr_wins got=%h exp=0", tgl_cnt); end
  endtask

  task automatic test_mixed();
    logic [2*WIDTH-1:0] m;
    for (int k = 0; k < 300; k++) begin
      m = (k < 40) ? 8'b11_10_01_00 : 8'($urandom);
      drive(4'($urandom_range(0, 15)) | ((k < 40) ? 4'b1111 : 4'b0000), m,
            4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
      total++; if (q !== m_q) begin bad++; $display("FAIL mixed_q k=%0d q=%b exp=%b", k, q, m_q); end
      total++; if (q_bar !== ~m_q) begin bad++; $display("FAIL mixed_qbar k=%0d got=%b exp=%b", k, q_bar, ~m_q); end
      total++; if (sr_err !== m_err) begin bad++; $display("FAIL mixed_sr_err k=%0d got=%b exp=%b", k, sr_err, m_err); end
      total++; if (tgl_cnt !== exp_cnt()) begin bad++; $display("FAIL mixed_cnt k=%0d got=%h exp=%h", k, tgl_cnt, exp_cnt()); end
      if (k == 150) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++; if (q !== RESET_VAL || tgl_cnt !== '0) begin bad++; $display("FAIL mid_reset q=%b cnt=%h exp q=%b cnt=0", q, tgl_cnt, RESET_VAL); end
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_t_mode();
    test_jk();
    test_sr();
    test_saturation();
    test_mixed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH independent single-bit flip-flops. Each channel is selectable at run time as D, T, JK or SR, with per-channel clock enable and a registered SR-conflict flag. It generalises the single T flip-flop into a reusable state-bit array for control logic, with optional per-channel transition counters for debug and coverage.

## Interface
Parameters:
- WIDTH, 8, number of channels (1..32)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of each transition counter (2..16)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  WIDTH  per-channel clock enable; 0 = hold
- mode  input  2*WIDTH  channel i uses bits [2i+1:2i]: 00 D, 01 T, 10 JK, 11 SR
- a  input  WIDTH  D / T / J / S input, by mode
- b  input  WIDTH  K / R input; ignored in D and T modes
- q  output  WIDTH  flip-flop state
- q_bar  output  WIDTH  always ~q
- sr_err  output  WIDTH  registered flag: SR channel saw S=R=1 while enabled
- cnt_clr  input  1  synchronous clear of all transition counters
- tgl_cnt  output  WIDTH*CNT_W  channel i count in bits [(i+1)*CNT_W-1 : i*CNT_W]

## Operation
- Channels are fully independent; mode, en, a and b are sampled per channel at each rising edge.
- en[i]=0: q[i] holds, sr_err[i] <= 0, no count.
- en[i]=1, next state per mode:
  - D: q <= a
  - T: a=1 toggles, a=0 holds
  - JK: 00 hold, 01 (J=0,K=1) reset, 10 set, 11 toggle
  - SR: 00 hold, 01 (S=0,R=1) reset, 10 set, 11 illegal: q holds, sr_err[i] <= 1
- sr_err[i] is a one-cycle registered flag, not sticky. It is 1 only for the cycle after an enabled S=R=1 sample.
- A mode change takes effect at the same edge it is sampled on. No transition state is kept across mode changes.
- q_bar is combinational ~q. It never differs from ~q, including during reset.
- Transition counter, when compiled in: tgl_cnt[i] increments on every edge where q[i] changes value.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - cnt_clr=1 zeroes all counters at the next edge.
  - If cnt_clr and a transition occur on the same edge, clear wins: the result is 0.

## Timing
- Reset, asynchronous assert: q=RESET_VAL, q_bar=~RESET_VAL, sr_err=0, all tgl_cnt=0 immediately, without waiting for clk.
- Reset release is synchronised by the caller. The first active edge is the first rising clk with rst=0.
- Reset asserted mid-operation overrides all inputs. The reset-to-RESET_VAL transition is not counted.
- Latency from input to q is 1 cycle. Latency from an S=R=1 sample to sr_err is 1 cycle.
- Counter update is in the same cycle as the q change it records.

## Configuration
- Macro: FF_BANK_TOGGLE_CNT_EN.
- Defined: per-channel saturating transition counters are instantiated as described.
- Undefined: no counter flops are built, tgl_cnt is tied to 0, and cnt_clr is ignored. The port list is unchanged.

## Test plan
- Reset: RESET_VAL=4'b1010, assert rst mid-cycle -> q=1010 and q_bar=0101 immediately; sr_err=0; tgl_cnt=0.
- T mode, all channels, en=1111, a=1111 for 3 edges from q=0000 -> q goes 1111, 0000, 1111. With macro, each tgl_cnt=3.
- JK on channel 0, JK inputs 10, 01, 11, 11, 00 from q=0 -> q goes 1, 0, 1, 0, 0. en=0 with JK=11 -> q holds.
- SR on channel 1, a=1 and b=1 with en=1 -> q[1] holds and sr_err[1]=1 for exactly one cycle. Then a=1, b=0 -> q[1]=1 and sr_err[1]=0.
- Counter saturation, CNT_W=2, macro defined: 5 toggles on channel 2 -> tgl_cnt[2]=3. cnt_clr together with a toggle -> count 0 while q still toggles.
- Mixed modes, mode=8'b11_10_01_00, in a single cycle -> each channel follows its own rule independently. Without the macro, tgl_cnt stays 0 throughout.
